// File: rtl/useq_v2.sv
`timescale 1ns/1ps
// useq_v2: parametrised 8-bit-opcode micro-sequencer with vectored prioritised
// interrupts, hardware call stack, output strobe and WAIT-for-IRQ stall.
module useq_v2 #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned NREG        = 16,
   parameter int unsigned N_IRQ       = 4,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned VEC_BASE    = 'hF0,
   parameter int unsigned VEC_STRIDE  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   input  logic [DATA_W-1:0] i_port,
   input  logic [N_IRQ-1:0]  irq,
   output logic [DATA_W-1:0] o_port,
   output logic              o_strobe,
   output logic              in_isr,
   output logic              stack_err
);
   localparam int unsigned IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int unsigned STK_IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);

   typedef enum logic [1:0] {FETCH, EXEC, IMM} state_t;

   typedef enum logic [3:0] {
      OP_NOP, OP_LDR, OP_STR, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_JMP, OP_JZ, OP_LDI, OP_CALL, OP_MISC, OP_MASK, OP_SHIFT, OP_RSVF
   } op_t;

   typedef enum logic [3:0] {
      M_RET, M_RTI, M_EI, M_DI, M_IN, M_OUT, M_WAIT
   } misc_t;

   state_t            state, state_next;
   logic [DATA_W-1:0] a;
   logic [ADDR_W-1:0] pc, ilr;
   logic [DATA_W-1:0] regs [2**IDX_W];
   logic [ADDR_W-1:0] stack [2**STK_IW];
   logic [SP_W-1:0]   sp, sp_dec;
   logic [N_IRQ-1:0]  mask, pending, irq_q;
   logic              c, ie;

   logic [N_IRQ-1:0]  irq_rise, active, take_sel;
   logic              take, stk_full, stk_empty;
   logic [ADDR_W-1:0] vec, pc_inc, pc_next, target;
   op_t               op;
   logic [3:0]        n;
   logic [IDX_W-1:0]  ridx;
   logic [DATA_W-1:0] rn;

   // Lowest-numbered unmasked pending line wins.
   always_comb begin
      irq_rise = irq & ~irq_q;
      active   = pending & mask;
      take_sel = '0;
      vec      = '0;
      for (int unsigned k = 0; k < N_IRQ; k++) begin
         if (active[k] && (take_sel == '0)) begin
            take_sel[k] = 1'b1;
            vec         = ADDR_W'(VEC_BASE + k * VEC_STRIDE);
         end
      end
      take = (state == FETCH) && ie && (active != '0);
   end

   always_comb begin
      op        = op_t'(mem_data[7:4]);
      n         = mem_data[3:0];
      ridx      = IDX_W'(int'(n) % int'(NREG));
      rn        = regs[ridx];
      target    = rn[ADDR_W-1:0];
      pc_inc    = pc + 1'b1;
      sp_dec    = sp - 1'b1;
      stk_full  = (sp == SP_W'(STACK_DEPTH));
      stk_empty = (sp == '0);

      pc_next = pc_inc;
      case (op)
         OP_JMP:  pc_next = target;
         OP_JZ:   if (a == '0) pc_next = target;
         OP_LDI:  pc_next = pc;
         OP_CALL: if (!stk_full) pc_next = target;
         OP_MISC: begin
            case (n)
               M_RET:   if (!stk_empty) pc_next = stack[sp_dec[STK_IW-1:0]];
               M_RTI:   pc_next = ilr;
               M_WAIT:  if (active == '0) pc_next = pc;
               default: ;
            endcase
         end
         default: ;
      endcase

      state_next = state;
      case (state)
         FETCH: if (!take) state_next = EXEC;
         EXEC: begin
            if (op == OP_LDI)
               state_next = IMM;
            else if ((op == OP_MISC) && (n == M_WAIT) && (active == '0))
               state_next = EXEC;
            else
               state_next = FETCH;
         end
         IMM:     state_next = FETCH;
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_next;
   end

   always_ff @(posedge clk) begin
      irq_q <= irq;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a         <= '0;
         pc        <= '0;
         ilr       <= '0;
         mask      <= '0;
         pending   <= '0;
         sp        <= '0;
         c         <= 1'b0;
         ie        <= 1'b0;
         regs      <= '{default: '0};
         stack     <= '{default: '0};
         mem_addr  <= '0;
         o_port    <= '0;
         o_strobe  <= 1'b0;
         in_isr    <= 1'b0;
         stack_err <= 1'b0;
      end else begin
         o_strobe <= 1'b0;
         // A new edge on a line being acknowledged this cycle keeps it pending.
         pending  <= (pending & ~(take ? take_sel : '0)) | irq_rise;
         case (state)
            FETCH: begin
               if (take) begin
                  ilr      <= pc;
                  ie       <= 1'b0;
                  in_isr   <= 1'b1;
                  pc       <= vec;
                  mem_addr <= vec;
               end
            end
            EXEC: begin
               pc       <= pc_next;
               mem_addr <= (op == OP_LDI) ? pc_inc : pc_next;
               case (op)
                  OP_LDR: a <= rn;
                  OP_STR: regs[ridx] <= a;
                  OP_ADD: {c, a} <= {1'b0, a} + {1'b0, rn};
                  OP_SUB: {c, a} <= {1'b0, a} - {1'b0, rn};
                  OP_AND: a <= a & rn;
                  OP_OR:  a <= a | rn;
                  OP_XOR: a <= a ^ rn;
                  OP_CALL: begin
                     if (stk_full) begin
                        stack_err <= 1'b1;
                     end else begin
                        stack[sp[STK_IW-1:0]] <= pc_inc;
                        sp <= sp + 1'b1;
                     end
                  end
                  OP_MISC: begin
                     case (n)
                        M_RET: begin
                           if (stk_empty) stack_err <= 1'b1;
                           else           sp <= sp_dec;
                        end
                        M_RTI: begin
                           ie     <= 1'b1;
                           in_isr <= 1'b0;
                        end
                        M_EI: ie <= 1'b1;
                        M_DI: ie <= 1'b0;
                        M_IN: a  <= i_port;
                        M_OUT: begin
                           o_port   <= a;
                           o_strobe <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
                  OP_MASK: mask <= a[N_IRQ-1:0];
                  OP_SHIFT: begin
                     if (n[0]) begin
                        c <= a[0];
                        a <= a >> 1;
                     end else begin
                        c <= a[DATA_W-1];
                        a <= a << 1;
                     end
                  end
                  default: ;
               endcase
            end
            IMM: begin
               a        <= DATA_W'(mem_data);
               pc       <= pc + ADDR_W'(2);
               mem_addr <= pc + ADDR_W'(2);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_useq_v2.sv
`timescale 1ns/1ps
// tb_useq_v2: directed bench for useq_v2; small programs in a ROM model,
// expected values worked out by hand from the cycle timing of each program.
module tb_useq_v2;
   logic       clk, rst_n;
   logic [7:0] mem_addr, mem_data;
   logic [7:0] i_port, o_port;
   logic [3:0] irq;
   logic       o_strobe, in_isr, stack_err;
   logic [7:0] rom [256];
   int         n_checks = 0;
   int         n_errors = 0;

   // mem_addr is the ROM's address register, so the array lookup is combinational.
   assign mem_data = rom[mem_addr];

   useq_v2 #(
      .DATA_W(8), .ADDR_W(8), .NREG(16), .N_IRQ(4),
      .STACK_DEPTH(4), .VEC_BASE('hF0), .VEC_STRIDE(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data(mem_data),
      .i_port(i_port), .irq(irq), .o_port(o_port), .o_strobe(o_strobe),
      .in_isr(in_isr), .stack_err(stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   // Holds reset for two edges with an all-NOP ROM; caller loads a program, then releases.
   task automatic begin_reset();
      rst_n  = 1'b0;
      irq    = '0;
      i_port = '0;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      run(2);
   endtask

   initial begin
      rst_n  = 1'b0;
      irq    = '0;
      i_port = '0;

      // LDI fetch/exec/imm sequence
      begin_reset();
      check("rst_a",        32'(dut.a), 32'h0);
      check("rst_pc",       32'(dut.pc), 32'h0);
      check("rst_mem_addr", 32'(mem_addr), 32'h0);
      check("rst_o_port",   32'(o_port), 32'h0);
      check("rst_flags",    32'({o_strobe, in_isr, stack_err}), 32'h0);
      rom[0] = 8'hA5; rom[1] = 8'h3C;
      rst_n = 1'b1;
      run(1); check("ldi_exec_addr", 32'(mem_addr), 32'h0);
      run(1); check("ldi_imm_addr",  32'(mem_addr), 32'h1);
              check("ldi_imm_a",     32'(dut.a), 32'h0);
      run(1); check("ldi_a",         32'(dut.a), 32'h3C);
              check("ldi_pc",        32'(dut.pc), 32'h2);

      // ADD carry, JZ, SUB borrow, SHR
      begin_reset();
      rom[8'h00] = 8'hA0; rom[8'h01] = 8'hFF; rom[8'h02] = 8'h21;
      rom[8'h03] = 8'hA0; rom[8'h04] = 8'h40; rom[8'h05] = 8'h22;
      rom[8'h06] = 8'hA0; rom[8'h07] = 8'h01; rom[8'h08] = 8'h31;
      rom[8'h09] = 8'h92;
      rom[8'h40] = 8'hA0; rom[8'h41] = 8'h05; rom[8'h42] = 8'h41;
      rom[8'h43] = 8'hE1; rom[8'h44] = 8'hE1;
      rst_n = 1'b1;
      run(15); check("add_a",  32'(dut.a), 32'h00);
               check("add_c",  32'(dut.c), 32'h1);
      run(2);  check("jz_mem_addr", 32'(mem_addr), 32'h40);
      run(5);  check("sub_a",  32'(dut.a), 32'h06);
               check("sub_c",  32'(dut.c), 32'h1);
      run(2);  check("shr1",   32'({dut.c, dut.a}), 32'h003);
      run(2);  check("shr2",   32'({dut.c, dut.a}), 32'h101);

      // call stack overflow and underflow
      begin_reset();
      rom[8'h00] = 8'hA0; rom[8'h01] = 8'h60; rom[8'h02] = 8'h21;
      rom[8'h03] = 8'hA0; rom[8'h04] = 8'h70; rom[8'h05] = 8'h22;
      rom[8'h06] = 8'hA0; rom[8'h07] = 8'h80; rom[8'h08] = 8'h23;
      rom[8'h09] = 8'hA0; rom[8'h0A] = 8'h90; rom[8'h0B] = 8'h24;
      rom[8'h0F] = 8'hB1; rom[8'h60] = 8'hB2; rom[8'h70] = 8'hB3;
      rom[8'h80] = 8'hB4; rom[8'h90] = 8'hB1;
      rom[8'h91] = 8'hC0; rom[8'h81] = 8'hC0; rom[8'h71] = 8'hC0;
      rom[8'h61] = 8'hC0; rom[8'h10] = 8'hC0;
      rst_n = 1'b1;
      run(34); check("call4_pc",  32'(dut.pc), 32'h90);
               check("call4_err", 32'(stack_err), 32'h0);
      run(2);  check("call5_pc",  32'(dut.pc), 32'h91);
               check("call5_err", 32'(stack_err), 32'h1);
      run(2);  check("ret1_pc",   32'(dut.pc), 32'h81);
      run(2);  check("ret2_pc",   32'(dut.pc), 32'h71);
      run(2);  check("ret3_pc",   32'(dut.pc), 32'h61);
      run(2);  check("ret4_pc",   32'(dut.pc), 32'h10);
      run(2);  check("ret5_pc",   32'(dut.pc), 32'h11);
               check("ret5_err",  32'(stack_err), 32'h1);

      // simultaneous irq[2]/irq[1] with mask 0110
      begin_reset();
      check("rst_clears_err", 32'(stack_err), 32'h0);
      rom[8'h00] = 8'hA0; rom[8'h01] = 8'h06; rom[8'h02] = 8'hD0;
      rom[8'h03] = 8'hC2; rom[8'hF4] = 8'hC1; rom[8'hF8] = 8'hC1;
      rst_n = 1'b1;
      run(7);
      irq = 4'b0110;
      run(1);
      irq = 4'b0000;
      run(2);  check("irq1_pc",      32'(dut.pc), 32'hF4);
               check("irq1_ilr",     32'(dut.ilr), 32'h05);
               check("irq1_in_isr",  32'(in_isr), 32'h1);
               check("irq1_pending", 32'(dut.pending), 32'h4);
      run(2);  check("rti1_pc",      32'(dut.pc), 32'h05);
               check("rti1_in_isr",  32'(in_isr), 32'h0);
      run(1);  check("irq2_pc",      32'(mem_addr), 32'hF8);
               check("irq2_pending", 32'(dut.pending), 32'h0);
               check("irq2_in_isr",  32'(in_isr), 32'h1);

      // masked irq[3] stays pending until unmasked
      begin_reset();
      rom[8'h00] = 8'hA0; rom[8'h01] = 8'h01; rom[8'h02] = 8'hD0;
      rom[8'h03] = 8'hC2; rom[8'h07] = 8'hA0; rom[8'h08] = 8'h08;
      rom[8'h09] = 8'hD0;
      rst_n = 1'b1;
      run(7);
      irq = 4'b1000;
      run(1);
      irq = 4'b0000;
      run(1);  check("masked_pending", 32'(dut.pending), 32'h8);
               check("masked_no_isr",  32'(in_isr), 32'h0);
      run(9);  check("unmask_pc",      32'(dut.pc), 32'h0A);
               check("unmask_no_isr",  32'(in_isr), 32'h0);
      run(1);  check("irq3_addr",      32'(mem_addr), 32'hFC);
               check("irq3_ilr",       32'(dut.ilr), 32'h0A);
               check("irq3_in_isr",    32'(in_isr), 32'h1);

      // WAIT with ie=0, then OUT strobe
      begin_reset();
      rom[8'h00] = 8'hA0; rom[8'h01] = 8'h01; rom[8'h02] = 8'hD0;
      rom[8'h03] = 8'hA0; rom[8'h04] = 8'h5A; rom[8'h05] = 8'hC6;
      rom[8'h06] = 8'hC5;
      rst_n = 1'b1;
      run(14); check("wait_pc",       32'(dut.pc), 32'h05);
               check("wait_mem_addr", 32'(mem_addr), 32'h05);
      irq = 4'b0001;
      run(1);
      irq = 4'b0000;
               check("wait_hold_pc",  32'(dut.pc), 32'h05);
      run(1);  check("wake_pc",       32'(dut.pc), 32'h06);
               check("wake_no_isr",   32'(in_isr), 32'h0);
      run(1);  check("strobe_before", 32'(o_strobe), 32'h0);
      run(1);  check("strobe_pulse",  32'(o_strobe), 32'h1);
               check("out_port",      32'(o_port), 32'h5A);
      run(1);  check("strobe_after",  32'(o_strobe), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
